alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer wrapped around the team's 8-bit combinational ALU (8-bit A/B, 3-bit opcode, 4-bit flags Z,N,C,V).
- Owns the accumulator (drives ALU A) and an operand register (drives ALU B).
- Applies one ALU operation repeatedly, N times, on a start/done handshake. This provides repeated add (multiply by constant), multi-bit shifts and iterated subtract.
- Sits between a simple host/control FSM and the ALU instance; the ALU itself stays external.

Parameters:
- CNT_W, 4, width of the iteration count (max N = 2^CNT_W - 1)

Ports:
- clock  in  1  system clock, rising edge
- nreset  in  1  asynchronous, active-low reset
- start  in  1  request to run; sampled in IDLE only
- load_acc  in  1  in IDLE: acc <= operand; takes priority over start
- abort  in  1  terminate a run early
- opr  in  3  ALU opcode: 0 passB, 1 sub, 2 add, 3 xor, 4 asr, 5 shl, 6 and, 7 or
- operand  in  8  B operand; latched on start or load_acc
- count  in  CNT_W  iteration count N
- alu_a  out  8  to ALU A (= acc)
- alu_b  out  8  to ALU B (= operand register)
- alu_opr  out  3  to ALU OPR (= latched opcode)
- alu_r  in  8  ALU result
- alu_flags  in  4  ALU flags {V,C,N,Z}
- acc  out  8  accumulator
- flags  out  4  flags of last executed iteration
- sticky_cv  out  2  {V,C} ORed over all iterations of the current run
- busy  out  1  high when state != IDLE
- done  out  1  one-cycle pulse at end of a completed run

Behaviour:
Reset (nreset low, asynchronous):
- state=IDLE
- acc=0x00, operand reg=0x00, opcode reg=0, cnt=0
- flags=0000, sticky_cv=00, busy=0, done=0
- Takes effect immediately mid-run; no done pulse is produced.

States:
- IDLE
  - load_acc=1: acc<=operand, operand reg<=operand; flags unchanged; start ignored that cycle.
  - Else start=1: latch opr, operand and count; sticky_cv<=00.
  - If count!=0: next state EXEC, cnt<=count. If count==0: next state DONE; acc and flags unchanged.
- EXEC
  - Every rising edge: acc<=alu_r, flags<=alu_flags, sticky_cv<=sticky_cv | alu_flags[3:2], cnt<=cnt-1.
  - When cnt==1 at the edge: next state DONE.
  - The ALU is purely combinational, so alu_r reflects the current acc within the same cycle.
- DONE
  - done=1 for exactly this cycle; next state IDLE unconditionally.

Abort:
- abort=1 in EXEC: next state IDLE with no write that edge; acc and flags keep the last completed iteration; no done pulse.
- abort is ignored in IDLE and DONE.
- If cnt==1 and abort=1 on the same edge, abort wins.

Timing:
- start sampled at edge k: N iterations complete at edges k+1..k+N.
- done is high during the cycle following edge k+N; busy falls after edge k+N+1.
- Total latency from start to done is N+1 cycles.

Other rules:
- start and load_acc while busy are ignored; inputs other than abort are don't-care in EXEC/DONE.
- Arithmetic is 8-bit modulo 2^8 (wrap-around as produced by the ALU); there is no saturation.
- alu_a/alu_b/alu_opr are held stable from register outputs and never glitch from inputs.

Test Plan:
- Reset mid-EXEC (nreset low 1 ns) -> acc=0x00, flags=0000, busy=0 immediately; no done pulse.
- Multiply by add: load_acc operand=0x00; start opr=2 operand=0x05 count=3 -> acc 0x05,0x0A,0x0F on successive edges; done 4 cycles after start; flags=0000; sticky_cv=00.
- Shift: load_acc 0x01; start opr=5 count=7 -> acc=0x80, flags N=1, Z=0; start opr=5 count=1 -> acc=0x00, flags Z=1.
- Overflow/carry sticky: load_acc 0x70; start opr=2 operand=0x10 count=2 -> acc 0x80 (V=1), then 0x90 (V=0); final flags V=0; sticky_cv V=1.
- count=0: load_acc 0x3C; start opr=2 operand=0x01 count=0 -> done one cycle after start; acc=0x3C; flags unchanged.
- Abort and ignore: start add 0x01 count=10 from acc=0; assert abort after 4th iteration edge -> acc=0x04, IDLE, no done pulse. A start re-pulsed while busy is ignored (iteration counting unaffected). Simultaneous start+load_acc in IDLE -> load only, busy stays 0.

Source files
------------

// File: rtl/alu_seq_ctrl_if.sv
// Host-side interface of the ALU sequencer.
// Carries the host's run/load/abort requests and run parameters toward the
// sequencer, and the accumulator, flags and status back to the host.
//   master : host / control FSM (drives requests, observes status)
//   slave  : alu_seq_ctrl (consumes requests, drives status)
// Signals:
//   start, load_acc, abort   request strobes
//   opr[2:0], operand[7:0]   ALU opcode and B operand
//   count[CNT_W-1:0]         iteration count N
//   acc[7:0], flags[3:0]     accumulator and last-iteration flags {V,C,N,Z}
//   sticky_cv[1:0]           {V,C} ORed over the current run
//   busy, done               status / end-of-run pulse
`timescale 1ns/1ps

interface alu_seq_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             load_acc;
  logic             abort;
  logic [2:0]       opr;
  logic [7:0]       operand;
  logic [CNT_W-1:0] count;
  logic [7:0]       acc;
  logic [3:0]       flags;
  logic [1:0]       sticky_cv;
  logic             busy;
  logic             done;

  modport master (
    output start, load_acc, abort, opr, operand, count,
    input  acc, flags, sticky_cv, busy, done
  );

  modport slave (
    input  start, load_acc, abort, opr, operand, count,
    output acc, flags, sticky_cv, busy, done
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer around an external 8-bit combinational ALU.
// Owns the accumulator (ALU A) and an operand register (ALU B) and applies
// one latched opcode N times per start/done handshake: repeated add, multi-bit
// shifts, iterated subtract and so on.
// Ports:
//   clock, nreset   rising-edge clock, asynchronous active-low reset
//   host            alu_seq_ctrl_if.slave: requests in, acc/flags/status out
//   alu_a, alu_b    ALU operands (accumulator, operand register)
//   alu_opr         ALU opcode (latched opcode register)
//   alu_r           ALU result
//   alu_flags       ALU flags {V,C,N,Z}
`timescale 1ns/1ps

module alu_seq_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic               clock,
  input  logic               nreset,
  alu_seq_ctrl_if.slave      host,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [2:0]         alu_opr,
  input  logic [7:0]         alu_r,
  input  logic [3:0]         alu_flags
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [7:0]       acc_q;
  logic [7:0]       opnd_q;
  logic [2:0]       opr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       flags_q;
  logic [1:0]       sticky_q;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the values from before the edge, including alu_r, which
  // is itself a function of acc_q.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state    <= S_IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      opr_q    <= '0;
      cnt_q    <= '0;
      flags_q  <= '0;
      sticky_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // load_acc outranks start; a start seen together with it is dropped.
          if (host.load_acc) begin
            acc_q  <= host.operand;
            opnd_q <= host.operand;
          end else if (host.start) begin
            opr_q    <= host.opr;
            opnd_q   <= host.operand;
            sticky_q <= '0;
            cnt_q    <= host.count;
            // A zero-length run still completes the handshake via DONE.
            state    <= (host.count != '0) ? S_EXEC : S_DONE;
          end
        end

        S_EXEC: begin
          // Abort leaves acc/flags at the last completed iteration, and wins
          // over the final iteration when both land on the same edge.
          if (host.abort) begin
            state <= S_IDLE;
          end else begin
            acc_q    <= alu_r;
            flags_q  <= alu_flags;
            sticky_q <= sticky_q | alu_flags[3:2];
            cnt_q    <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state <= S_DONE;
          end
        end

        S_DONE: state <= S_IDLE;

        // NOTE: the unused encoding recovers to IDLE rather than locking up.
        default: state <= S_IDLE;
      endcase
    end
  end

  // ALU inputs come straight from registers so they never glitch with host
  // inputs while the ALU is settling.
  assign alu_a          = acc_q;
  assign alu_b          = opnd_q;
  assign alu_opr        = opr_q;

  assign host.acc       = acc_q;
  assign host.flags     = flags_q;
  assign host.sticky_cv = sticky_q;
  assign host.busy      = (state != S_IDLE);
  assign host.done      = (state == S_DONE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl. Provides a behavioural model of the
// external 8-bit ALU, a scoreboard of expected end-of-run results, a table of
// run vectors and hand-written sequences for iteration trace, abort, busy
// start, start+load priority and asynchronous reset mid-run.
`timescale 1ns/1ps

module tb_alu_seq_ctrl;

  localparam int CNT_W = 4;

  logic       clock;
  logic       nreset;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_opr;
  logic [7:0] alu_r;
  logic [3:0] alu_flags;

  alu_seq_ctrl_if #(.CNT_W(CNT_W)) host ();

  alu_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .host      (host),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_opr   (alu_opr),
    .alu_r     (alu_r),
    .alu_flags (alu_flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU: flags are {V,C,N,Z}; C is carry-out for add, borrow for
  // sub, the shifted-out bit for shifts.
  always_comb begin
    logic [8:0] t;
    logic       c;
    logic       v;
    t = '0;
    c = 1'b0;
    v = 1'b0;
    alu_r = '0;
    case (alu_opr)
      3'd0: alu_r = alu_b;
      3'd1: begin
        t = {1'b0, alu_a} - {1'b0, alu_b};
        alu_r = t[7:0];
        c = t[8];
        v = (alu_a[7] ^ alu_b[7]) & (alu_r[7] ^ alu_a[7]);
      end
      3'd2: begin
        t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r = t[7:0];
        c = t[8];
        v = ~(alu_a[7] ^ alu_b[7]) & (alu_r[7] ^ alu_a[7]);
      end
      3'd3: alu_r = alu_a ^ alu_b;
      3'd4: begin
        alu_r = {alu_a[7], alu_a[7:1]};
        c = alu_a[0];
      end
      3'd5: begin
        alu_r = {alu_a[6:0], 1'b0};
        c = alu_a[7];
      end
      3'd6: alu_r = alu_a & alu_b;
      default: alu_r = alu_a | alu_b;
    endcase
    alu_flags = {v, c, alu_r[7], (alu_r == 8'h00)};
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Posedge counter used for latency measurement.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] acc;
    logic [3:0] flags;
    logic [1:0] sticky;
    int         start_cyc;
    int         n;
  } exp_t;

  exp_t sb_q[$];
  int   done_cnt = 0;
  int   runs_expected = 0;

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clock) begin
    if (nreset && host.done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("run_acc",     32'(host.acc),       32'(e.acc));
        check("run_flags",   32'(host.flags),     32'(e.flags));
        check("run_sticky",  32'(host.sticky_cv), 32'(e.sticky));
        check("run_latency", 32'(cyc - e.start_cyc), 32'(e.n + 1));
      end
    end
  end

  task automatic load_acc_val(input logic [7:0] v);
    @(negedge clock);
    host.load_acc = 1'b1;
    host.operand  = v;
    @(negedge clock);
    host.load_acc = 1'b0;
  endtask

  // Drives a one-cycle start; returns at the negedge right after the start edge.
  task automatic start_run(input logic [2:0] o, input logic [7:0] b, input logic [3:0] n,
                           input logic [7:0] ea, input logic [3:0] ef, input logic [1:0] es,
                           input bit expect_done);
    @(negedge clock);
    host.opr     = o;
    host.operand = b;
    host.count   = n;
    host.start   = 1'b1;
    if (expect_done) begin
      sb_q.push_back('{acc: ea, flags: ef, sticky: es, start_cyc: cyc, n: int'(n)});
      runs_expected++;
    end
    @(negedge clock);
    host.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40 && done_cnt < runs_expected; i++) begin
      @(negedge clock);
      #1;
    end
    check({name, "_done_seen"}, 32'(done_cnt), 32'(runs_expected));
    @(negedge clock);
    #1;
    check({name, "_done_pulse_len"}, 32'(host.done), 32'd0);
    check({name, "_idle_after"},     32'(host.busy), 32'd0);
  endtask

  typedef struct {
    logic       do_load;
    logic [7:0] load_val;
    logic [2:0] opr;
    logic [7:0] operand;
    logic [3:0] count;
    logic [7:0] exp_acc;
    logic [3:0] exp_flags;
    logic [1:0] exp_sticky;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          load  lval   opr   oprnd  cnt    acc    flags  sticky
    vecs[0]  = '{1'b1, 8'h00, 3'd2, 8'h05, 4'd3,  8'h0F, 4'h0, 2'b00}; // multiply by add
    vecs[1]  = '{1'b1, 8'h01, 3'd5, 8'h00, 4'd7,  8'h80, 4'h2, 2'b00}; // shl x7
    vecs[2]  = '{1'b0, 8'h00, 3'd5, 8'h00, 4'd1,  8'h00, 4'h5, 2'b01}; // shl out, Z and C
    vecs[3]  = '{1'b1, 8'h70, 3'd2, 8'h10, 4'd2,  8'h90, 4'h2, 2'b10}; // V sticky only
    vecs[4]  = '{1'b1, 8'h3C, 3'd2, 8'h01, 4'd0,  8'h3C, 4'h2, 2'b00}; // count 0, flags kept
    vecs[5]  = '{1'b1, 8'h10, 3'd1, 8'h03, 4'd4,  8'h04, 4'h0, 2'b00}; // iterated sub
    vecs[6]  = '{1'b1, 8'h02, 3'd1, 8'h01, 4'd3,  8'hFF, 4'h6, 2'b01}; // sub wraps, borrow
    vecs[7]  = '{1'b1, 8'h81, 3'd4, 8'h00, 4'd2,  8'hE0, 4'h2, 2'b01}; // asr
    vecs[8]  = '{1'b1, 8'h5A, 3'd3, 8'hFF, 4'd3,  8'hA5, 4'h2, 2'b00}; // xor
    vecs[9]  = '{1'b1, 8'h11, 3'd0, 8'h00, 4'd1,  8'h00, 4'h1, 2'b00}; // passB
    vecs[10] = '{1'b1, 8'hF3, 3'd6, 8'h3C, 4'd1,  8'h30, 4'h0, 2'b00}; // and
    vecs[11] = '{1'b1, 8'h01, 3'd7, 8'h80, 4'd2,  8'h81, 4'h2, 2'b00}; // or
    vecs[12] = '{1'b1, 8'h00, 3'd2, 8'h11, 4'd15, 8'hFF, 4'h2, 2'b10}; // max count

    nreset        = 1'b0;
    host.start    = 1'b0;
    host.load_acc = 1'b0;
    host.abort    = 1'b0;
    host.opr      = '0;
    host.operand  = '0;
    host.count    = '0;
    repeat (2) @(negedge clock);
    #1;
    check("reset_acc",    32'(host.acc),       32'h00);
    check("reset_flags",  32'(host.flags),     32'h0);
    check("reset_sticky", 32'(host.sticky_cv), 32'h0);
    check("reset_busy",   32'(host.busy),      32'd0);
    check("reset_done",   32'(host.done),      32'd0);
    check("reset_alu_b",  32'(alu_b),          32'h00);
    check("reset_alu_op", 32'(alu_opr),        32'h0);
    @(negedge clock);
    nreset = 1'b1;

    // Iteration trace of multiply-by-add.
    load_acc_val(8'h00);
    start_run(3'd2, 8'h05, 4'd3, 8'h0F, 4'h0, 2'b00, 1'b1);
    #1;
    check("trace_busy", 32'(host.busy), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      #1;
      check($sformatf("trace_acc_%0d", i), 32'(host.acc), 32'(8'(5 * i)));
    end
    wait_done("trace");

    // Table-driven runs.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_load) load_acc_val(vecs[i].load_val);
      start_run(vecs[i].opr, vecs[i].operand, vecs[i].count,
                vecs[i].exp_acc, vecs[i].exp_flags, vecs[i].exp_sticky, 1'b1);
      wait_done($sformatf("vec%0d", i));
    end

    // Abort after the 4th iteration, with an ignored start re-pulse mid-run.
    load_acc_val(8'h00);
    start_run(3'd2, 8'h01, 4'd10, 8'h00, 4'h0, 2'b00, 1'b0);
    repeat (2) @(negedge clock);             // after edge k+2
    host.start   = 1'b1;
    host.opr     = 3'd3;
    host.operand = 8'h55;
    host.count   = 4'd2;
    @(negedge clock);                        // after edge k+3
    host.start = 1'b0;
    #1;
    check("busy_start_opr", 32'(alu_opr),  32'd2);
    check("busy_start_b",   32'(alu_b),    32'h01);
    check("busy_start_acc", 32'(host.acc), 32'h03);
    @(negedge clock);                        // after edge k+4
    #1;
    check("abort_pre_acc", 32'(host.acc), 32'h04);
    host.abort = 1'b1;
    @(negedge clock);                        // after abort edge
    host.abort = 1'b0;
    #1;
    check("abort_acc",   32'(host.acc),   32'h04);
    check("abort_flags", 32'(host.flags), 32'h0);
    check("abort_busy",  32'(host.busy),  32'd0);
    repeat (15) @(negedge clock);
    #1;
    check("abort_no_done", 32'(done_cnt), 32'(runs_expected));
    check("abort_acc_held", 32'(host.acc), 32'h04);

    // start + load_acc together: load only.
    @(negedge clock);
    host.load_acc = 1'b1;
    host.start    = 1'b1;
    host.operand  = 8'h77;
    host.count    = 4'd3;
    @(negedge clock);
    host.load_acc = 1'b0;
    host.start    = 1'b0;
    #1;
    check("ldst_acc",  32'(host.acc),  32'h77);
    check("ldst_busy", 32'(host.busy), 32'd0);
    repeat (2) @(negedge clock);
    #1;
    check("ldst_busy_later", 32'(host.busy), 32'd0);

    // Asynchronous reset mid-EXEC.
    load_acc_val(8'h7E);
    start_run(3'd2, 8'h01, 4'd10, 8'h00, 4'h0, 2'b00, 1'b0);
    repeat (3) @(negedge clock);
    #1;
    check("prerst_acc",    32'(host.acc),       32'h81);
    check("prerst_sticky", 32'(host.sticky_cv), 32'b10);
    nreset = 1'b0;
    #0.5;
    check("rst_acc",    32'(host.acc),       32'h00);
    check("rst_flags",  32'(host.flags),     32'h0);
    check("rst_sticky", 32'(host.sticky_cv), 32'h0);
    check("rst_busy",   32'(host.busy),      32'd0);
    #0.5;
    nreset = 1'b1;
    repeat (15) @(negedge clock);
    #1;
    check("rst_no_done",   32'(done_cnt),  32'(runs_expected));
    check("rst_idle",      32'(host.busy), 32'd0);
    check("sb_drained",    32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
